project_output_mux: RTL and testbench

Parametrised, registered successor of the chip-level project output multiplexer. It selects one of `NUM_PROJ` project output buses onto the shared pad outputs. The asynchronous `design_sel_in` pad select is synchronised, and a new select value must be stable before it is accepted. Outputs are blanked while a switch is in progress, and the newly selected project receives a reset pulse. It sits between the project macros and the pad ring; project inputs stay wired in parallel outside this block.

---
 rtl/project_mux_pkg.sv | 22 ++
 rtl/sel_synchronizer.sv | 38 +++
 rtl/project_output_mux.sv | 153 +++++++++++++++
 tb/tb_project_output_mux.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/project_mux_pkg.sv
// ---------------------------------------------------------------------------
// project_mux_pkg
// Shared types and default parameter values for the project output mux.
//   state_t       : switch-sequencing FSM states
//   DEF_*         : default values for the project_output_mux parameters
// ---------------------------------------------------------------------------
package project_mux_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_PULSE  = 2'd2
    } state_t;

    localparam int DEF_NUM_PROJ      = 8;
    localparam int DEF_OUT_W         = 11;
    localparam int DEF_SEL_W         = 3;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_RST_CYCLES    = 4;

endpackage

// File: rtl/sel_synchronizer.sv
// ---------------------------------------------------------------------------
// sel_synchronizer
// N-stage multi-bit flop chain bringing the asynchronous pad select into the
// clk domain. Multi-bit skew is tolerated because the consumer requires the
// synchronised value to be stable for several cycles before using it.
//   clk  : clock
//   rst  : synchronous active-high reset, clears every stage
//   d_i  : asynchronous input
//   q_o  : last synchronised stage
// ---------------------------------------------------------------------------
module sel_synchronizer #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/project_output_mux.sv
// ---------------------------------------------------------------------------
// project_output_mux
// Selects one of NUM_PROJ project output buses onto the shared pad outputs.
// A new select must be stable for STABLE_CYCLES before it is committed; the
// outputs are blanked while switching and the new project gets a reset pulse
// of RST_CYCLES.
//   clk            : clock
//   rst            : synchronous active-high reset
//   design_sel_in  : asynchronous pad select
//   proj_out_in    : flattened project outputs, project p at [p*OUT_W +: OUT_W]
//   mux_out        : registered pad outputs
//   proj_rst_out   : per-project active-high reset
//   active_sel_out : committed select
//   switching_out  : high whenever the FSM is not in RUN
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_RUN    | committed project drives mux_out
// ST_SETTLE | candidate select waiting to be stable; outputs blanked
// ST_PULSE  | committed project held in reset; outputs blanked
// ---------------------------------------------------------------------------
module project_output_mux
    import project_mux_pkg::*;
#(
    parameter int NUM_PROJ      = DEF_NUM_PROJ,
    parameter int OUT_W         = DEF_OUT_W,
    parameter int SEL_W         = DEF_SEL_W,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int RST_CYCLES    = DEF_RST_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SEL_W-1:0]          design_sel_in,
    input  logic [NUM_PROJ*OUT_W-1:0] proj_out_in,
    output logic [OUT_W-1:0]          mux_out,
    output logic [NUM_PROJ-1:0]       proj_rst_out,
    output logic [SEL_W-1:0]          active_sel_out,
    output logic                      switching_out
);

    localparam int CNT_MAX = (STABLE_CYCLES > RST_CYCLES) ? STABLE_CYCLES : RST_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);

    // Out-of-range selects map to an all-zero vector.
    function automatic logic [NUM_PROJ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        logic [NUM_PROJ-1:0] oh;
        oh = '0;
        for (int p = 0; p < NUM_PROJ; p++) begin
            oh[p] = (int'(s) == p);
        end
        return oh;
    endfunction

    logic [SEL_W-1:0] sel_sync;

    sel_synchronizer #(
        .WIDTH  (SEL_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (design_sel_in),
        .q_o (sel_sync)
    );

    state_t              state_q,  state_d;
    logic [SEL_W-1:0]    cand_q,   cand_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [SEL_W-1:0]    active_q, active_d;
    logic [NUM_PROJ-1:0] prst_q,   prst_d;
    logic [OUT_W-1:0]    mux_q,    mux_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_PULSE;
            cand_q   <= '0;
            cnt_q    <= '0;
            active_q <= '0;
            prst_q   <= '1;
            mux_q    <= '0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            prst_q   <= prst_d;
            mux_q    <= mux_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        prst_d   = prst_q;
        unique case (state_q)
            ST_RUN: begin
                if (sel_sync != active_q) begin
                    state_d = ST_SETTLE;
                    cand_d  = sel_sync;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (sel_sync == active_q) begin
                    state_d = ST_RUN;
                end else if (sel_sync != cand_q) begin
                    cand_d = sel_sync;
                    cnt_d  = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d  = ST_PULSE;
                    active_d = cand_q;
                    cnt_d    = '0;
                    prst_d   = sel_onehot(cand_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_RUN;
                    prst_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_PULSE;
                cnt_d   = '0;
            end
        endcase
    end

    // Only a committed, in-range select in RUN reaches the pads.
    always_comb begin
        mux_d = '0;
        for (int p = 0; p < NUM_PROJ; p++) begin
            if (state_q == ST_RUN && int'(active_q) == p) begin
                mux_d = proj_out_in[p*OUT_W +: OUT_W];
            end
        end
    end

    assign mux_out        = mux_q;
    assign proj_rst_out   = prst_q;
    assign active_sel_out = active_q;
    assign switching_out  = (state_q != ST_RUN);

endmodule

// File: tb/tb_project_output_mux.sv
module tb_project_output_mux;

    localparam int NP = 8;
    localparam int OW = 11;
    localparam int SW = 3;
    localparam int SYNC = 2;
    localparam int STABLE = 4;
    localparam int RSTC = 4;

    localparam int M_RUN = 0;
    localparam int M_SETTLE = 1;
    localparam int M_PULSE = 2;

    logic            clk;
    logic            rst;
    logic [SW-1:0]   sel;
    logic [NP*OW-1:0] proj_in;
    logic [OW-1:0]   mux_o;
    logic [NP-1:0]   prst_o;
    logic [SW-1:0]   act_o;
    logic            sw_o;

    logic [SW-1:0]   sel6;
    logic [6*OW-1:0] proj6;
    logic [OW-1:0]   mux6;
    logic [5:0]      prst6;
    logic [SW-1:0]   act6;
    logic            sw6;

    int total = 0;
    int bad = 0;

    project_output_mux dut (
        .clk            (clk),
        .rst            (rst),
        .design_sel_in  (sel),
        .proj_out_in    (proj_in),
        .mux_out        (mux_o),
        .proj_rst_out   (prst_o),
        .active_sel_out (act_o),
        .switching_out  (sw_o)
    );

    project_output_mux #(.NUM_PROJ(6), .OUT_W(OW), .SEL_W(SW)) dut6 (
        .clk            (clk),
        .rst            (rst),
        .design_sel_in  (sel6),
        .proj_out_in    (proj6),
        .mux_out        (mux6),
        .proj_rst_out   (prst6),
        .active_sel_out (act6),
        .switching_out  (sw6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] slice_of(input int p);
        return proj_in[p*OW +: OW];
    endfunction

    // ---------------- behavioural model of the default instance ----------------
    // Expressed with absolute edge deadlines rather than counters.
    int            cyc = 0;
    int            m_mode;
    int            m_active, m_cand;
    int            commit_at, pulse_end;
    logic [NP-1:0] m_prst;
    logic [OW-1:0] m_mux;
    logic [SW-1:0] m_pipe [SYNC];
    bit            m_valid = 0;

    always @(posedge clk) begin
        int s;
        s = int'(m_pipe[SYNC-1]);
        cyc++;
        if (rst) begin
            for (int i = 0; i < SYNC; i++) m_pipe[i] = '0;
            m_mode = M_PULSE;
            pulse_end = cyc + RSTC;
            m_active = 0;
            m_cand = 0;
            m_prst = '1;
            m_mux = '0;
            m_valid = 1;
        end else if (m_valid) begin
            for (int i = SYNC-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = sel;
            m_mux = (m_mode == M_RUN && m_active < NP) ? slice_of(m_active) : '0;
            case (m_mode)
                M_RUN: begin
                    if (s != m_active) begin
                        m_mode = M_SETTLE;
                        m_cand = s;
                        commit_at = cyc + STABLE;
                    end
                end
                M_SETTLE: begin
                    if (s == m_active) begin
                        m_mode = M_RUN;
                    end else if (s != m_cand) begin
                        m_cand = s;
                        commit_at = cyc + STABLE;
                    end else if (cyc == commit_at) begin
                        m_active = m_cand;
                        m_prst = (m_cand < NP) ? NP'(1) << m_cand : '0;
                        m_mode = M_PULSE;
                        pulse_end = cyc + RSTC;
                    end
                end
                default: begin
                    if (cyc == pulse_end) begin
                        m_mode = M_RUN;
                        m_prst = '0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_mux", mux_o, m_mux);
            chk("model_prst", prst_o, m_prst);
            chk("model_active", act_o, m_active);
            chk("model_switching", sw_o, (m_mode != M_RUN));
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_post_reset();
        chk("post_rst_prst_k0", prst_o, 8'hFF);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            chk("post_rst_prst", prst_o, (k <= 3) ? 8'hFF : 8'h00);
            chk("post_rst_mux", mux_o, (k >= 5) ? 11'h5A5 : 11'h000);
            chk("post_rst_sw", sw_o, (k <= 3));
            chk("post_rst_active", act_o, 0);
        end
    endtask

    initial begin
        int zeros;
        rst = 1'b1;
        sel = '0;
        sel6 = '0;
        for (int p = 0; p < NP; p++) proj_in[p*OW +: OW] = OW'(p * 11'h011 + 11'h001);
        proj_in[0*OW +: OW] = 11'h5A5;
        proj_in[2*OW +: OW] = 11'h222;
        proj_in[3*OW +: OW] = 11'h333;
        proj_in[5*OW +: OW] = 11'h3C3;
        for (int p = 0; p < 6; p++) proj6[p*OW +: OW] = OW'(11'h0AB + p);

        step(3);
        chk("reset_prst", prst_o, 8'hFF);
        chk("reset_mux", mux_o, 0);
        chk("reset_active", act_o, 0);
        chk("reset_sw", sw_o, 1);
        rst = 1'b0;
        check_post_reset();
        step(3);

        // one-cycle glitch 0 -> 3 -> 0
        sel = 3'd3;
        step(1);
        sel = 3'd0;
        zeros = 0;
        for (int k = 2; k <= 8; k++) begin
            step(1);
            if (mux_o == 0) zeros++;
            chk("glitch_prst", prst_o, 0);
            chk("glitch_active", act_o, 0);
        end
        chk("glitch_zero_cycles", zeros, 1);
        step(3);

        // stable step 0 -> 5
        sel = 3'd5;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            chk("step_mux", mux_o, (k <= 3) ? 11'h5A5 : ((k <= 11) ? 11'h000 : 11'h3C3));
            chk("step_prst", prst_o, (k >= 7 && k <= 10) ? 8'h20 : 8'h00);
            chk("step_active", act_o, (k >= 7) ? 5 : 0);
            chk("step_sw", sw_o, (k >= 3 && k <= 10));
        end
        step(3);

        // bounce 2,3,2 then hold 2
        sel = 3'd2;
        step(1);
        sel = 3'd3;
        step(1);
        sel = 3'd2;
        for (int k = 3; k <= 15; k++) begin
            step(1);
            chk("bounce_prst", prst_o, (k >= 9 && k <= 12) ? 8'h04 : 8'h00);
            chk("bounce_active", act_o, (k >= 9) ? 2 : 5);
        end
        chk("bounce_mux", mux_o, 11'h222);
        step(3);

        // reset during PULSE
        sel = 3'd5;
        step(8);
        chk("midpulse_prst", prst_o, 8'h20);
        rst = 1'b1;
        sel = 3'd0;
        step(1);
        chk("abort_prst", prst_o, 8'hFF);
        chk("abort_mux", mux_o, 0);
        chk("abort_active", act_o, 0);
        step(1);
        rst = 1'b0;
        check_post_reset();
        step(3);

        // 6-project instance, out-of-range select 7
        chk("np6_pre_mux", mux6, 11'h0AB);
        sel6 = 3'd7;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            chk("np6_mux", mux6, (k <= 3) ? 11'h0AB : 11'h000);
            chk("np6_prst", prst6, 0);
            chk("np6_active", act6, (k >= 7) ? 7 : 0);
        end
        chk("np6_sw_run", sw6, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
